// File: rtl/gzip_sched_pkg.sv
// Shared types for the gzip job scheduler: FSM states, status codes
// and the command-queue entry.
package gzip_sched_pkg;

  localparam int TAG_MAX_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_CAPTURE,
    S_REPORT
  } state_e;

  localparam logic [1:0] CODE_OK        = 2'd0;
  localparam logic [1:0] CODE_BTYPE_ERR = 2'd1;
  localparam logic [1:0] CODE_BSIZE_ERR = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd3;

  typedef struct packed {
    logic [1:0]           btype;
    logic                 rev_endian;
    logic                 irq_en;
    logic [TAG_MAX_W-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/gzip_cmd_fifo.sv
// Show-ahead command queue; the head entry is visible on rd_data
// whenever the queue is not empty. DEPTH must be a power of two >= 2.
module gzip_cmd_fifo
  import gzip_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  cmd_t        mem_q [DEPTH];
  cmd_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full queue is legal only when the head leaves now.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/gzip_job_sched.sv
// Job scheduler for a gzip compressor core: queues commands, resets
// and runs the core per job, watches for errors/timeout, reports status.
module gzip_job_sched
  import gzip_sched_pkg::*;
#(
  parameter int CMD_DEPTH  = 4,
  parameter int RST_CYCLES = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 core_clock,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_btype,
  input  logic                 cmd_rev_endian,
  input  logic                 cmd_irq_en,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  input  logic [23:0]          timeout_cycles,
  output logic                 core_rst_n,
  output logic [1:0]           core_btype,
  output logic                 core_rev_endian,
  input  logic                 core_done,
  input  logic                 core_btype_err,
  input  logic                 core_bsize_err,
  input  logic [31:0]          core_isize,
  input  logic [31:0]          core_crc,
  output logic                 sts_valid,
  input  logic                 sts_ready,
  output logic [TAG_WIDTH-1:0] sts_tag,
  output logic [1:0]           sts_code,
  output logic [31:0]          sts_isize,
  output logic [31:0]          sts_crc,
  output logic                 irq
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [RCW-1:0] RC_ONE  = 1;

  state_e               state_q, state_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  logic [23:0]          cnt_q, cnt_d;
  cmd_t                 job_q, job_d;
  logic [1:0]           code_q, code_d;
  logic [TAG_WIDTH-1:0] sts_tag_q, sts_tag_d;
  logic [1:0]           sts_code_q, sts_code_d;
  logic [31:0]          sts_isize_q, sts_isize_d;
  logic [31:0]          sts_crc_q, sts_crc_d;
  logic                 rdy_q, rdy_d;

  cmd_t fifo_wr;
  cmd_t fifo_rd;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic unused_tag;

  always_comb begin
    fifo_wr            = '0;
    fifo_wr.btype      = cmd_btype;
    fifo_wr.rev_endian = cmd_rev_endian;
    fifo_wr.irq_en     = cmd_irq_en;
    fifo_wr.tag        = TAG_MAX_W'(cmd_tag);
  end

  gzip_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (core_clock),
    .rst_n   (rst_n),
    .push    (cmd_valid && cmd_ready),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // rdy_q holds cmd_ready low until the first edge after reset release.
  assign rdy_d     = 1'b1;
  assign cmd_ready = rdy_q && (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    cnt_d       = cnt_q;
    job_d       = job_q;
    code_d      = code_q;
    sts_tag_d   = sts_tag_q;
    sts_code_d  = sts_code_q;
    sts_isize_d = sts_isize_q;
    sts_crc_d   = sts_crc_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          job_d   = fifo_rd;
          cnt_d   = '0;
          rcnt_d  = '0;
          state_d = S_RESET;
        end
      end
      S_RESET: begin
        if (rcnt_q == RC_LAST) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + RC_ONE;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
        if (core_btype_err) begin
          code_d  = CODE_BTYPE_ERR;
          state_d = S_CAPTURE;
        end else if (core_bsize_err) begin
          code_d  = CODE_BSIZE_ERR;
          state_d = S_CAPTURE;
        end else if (core_done) begin
          code_d  = CODE_OK;
          state_d = S_CAPTURE;
        end else if (timeout_cycles != 24'd0 &&
                     cnt_q == timeout_cycles - 24'd1) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        sts_tag_d   = job_q.tag[TAG_WIDTH-1:0];
        sts_code_d  = code_q;
        sts_isize_d = core_isize;
        sts_crc_d   = core_crc;
        state_d     = S_REPORT;
      end
      S_REPORT: begin
        if (sts_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      cnt_q       <= '0;
      job_q       <= '0;
      code_q      <= CODE_OK;
      sts_tag_q   <= '0;
      sts_code_q  <= '0;
      sts_isize_q <= '0;
      sts_crc_q   <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      cnt_q       <= cnt_d;
      job_q       <= job_d;
      code_q      <= code_d;
      sts_tag_q   <= sts_tag_d;
      sts_code_q  <= sts_code_d;
      sts_isize_q <= sts_isize_d;
      sts_crc_q   <= sts_crc_d;
      rdy_q       <= rdy_d;
    end
  end

  assign core_rst_n      = (state_q == S_RUN) || (state_q == S_CAPTURE) ||
                           (state_q == S_REPORT);
  assign core_btype      = job_q.btype;
  assign core_rev_endian = job_q.rev_endian;
  assign sts_valid       = (state_q == S_REPORT);
  assign sts_tag         = sts_tag_q;
  assign sts_code        = sts_code_q;
  assign sts_isize       = sts_isize_q;
  assign sts_crc         = sts_crc_q;
  assign irq             = sts_valid && job_q.irq_en;
  assign unused_tag      = ^job_q.tag;

endmodule

// File: tb/tb_gzip_job_sched.sv
// Directed self-checking bench for gzip_job_sched.
module tb_gzip_job_sched;

  logic        core_clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_btype = 2'd0;
  logic        cmd_rev_endian = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic [3:0]  cmd_tag = 4'd0;
  logic [23:0] timeout_cycles = 24'd0;
  logic        core_rst_n;
  logic [1:0]  core_btype;
  logic        core_rev_endian;
  logic        core_done = 1'b0;
  logic        core_btype_err = 1'b0;
  logic        core_bsize_err = 1'b0;
  logic [31:0] core_isize = 32'd0;
  logic [31:0] core_crc = 32'd0;
  logic        sts_valid;
  logic        sts_ready = 1'b0;
  logic [3:0]  sts_tag;
  logic [1:0]  sts_code;
  logic [31:0] sts_isize;
  logic [31:0] sts_crc;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  gzip_job_sched #(
    .CMD_DEPTH  (4),
    .RST_CYCLES (16),
    .TAG_WIDTH  (4)
  ) dut (
    .core_clock      (core_clock),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_btype       (cmd_btype),
    .cmd_rev_endian  (cmd_rev_endian),
    .cmd_irq_en      (cmd_irq_en),
    .cmd_tag         (cmd_tag),
    .timeout_cycles  (timeout_cycles),
    .core_rst_n      (core_rst_n),
    .core_btype      (core_btype),
    .core_rev_endian (core_rev_endian),
    .core_done       (core_done),
    .core_btype_err  (core_btype_err),
    .core_bsize_err  (core_bsize_err),
    .core_isize      (core_isize),
    .core_crc        (core_crc),
    .sts_valid       (sts_valid),
    .sts_ready       (sts_ready),
    .sts_tag         (sts_tag),
    .sts_code        (sts_code),
    .sts_isize       (sts_isize),
    .sts_crc         (sts_crc),
    .irq             (irq)
  );

  always #5 core_clock = ~core_clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge core_clock);
  endtask

  task automatic push(input logic [1:0] bt, input logic rev,
                      input logic ie, input logic [3:0] tg);
    int k = 0;
    cmd_valid      = 1'b1;
    cmd_btype      = bt;
    cmd_rev_endian = rev;
    cmd_irq_en     = ie;
    cmd_tag        = tg;
    while (!cmd_ready && k < 500) begin
      tick();
      k++;
    end
    chk("push_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (!core_rst_n && k < 500) begin
      tick();
      k++;
    end
    chk("run_reached", 64'(core_rst_n), 64'd1);
  endtask

  task automatic do_job(input logic [3:0] exp_tag, input int hold);
    wait_run();
    repeat (3) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("job_sts_valid", 64'(sts_valid), 64'd1);
    chk("job_sts_tag", 64'(sts_tag), 64'(exp_tag));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(sts_valid), 64'd1);
      chk("hold_tag", 64'(sts_tag), 64'(exp_tag));
      chk("hold_no_reset", 64'(core_rst_n), 64'd1);
    end
    sts_ready = 1'b1;
    tick();
    sts_ready = 1'b0;
    chk("job_sts_drop", 64'(sts_valid), 64'd0);
  endtask

  initial begin
    int n;
    int acc;
    int seen;

    // Reset state
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_sts_valid", 64'(sts_valid), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_core_btype", 64'(core_btype), 64'd0);
    rst_n = 1'b1;
    chk("rdy_before_edge", 64'(cmd_ready), 64'd0);
    tick();
    chk("rdy_after_edge", 64'(cmd_ready), 64'd1);

    // Basic job: btype 1, tag 5, irq on, done 100 cycles into RUN
    push(2'd1, 1'b1, 1'b1, 4'd5);
    n = 0;
    while (core_btype != 2'd1 && n < 10) begin
      tick();
      n++;
    end
    chk("pop_btype", 64'(core_btype), 64'd1);
    chk("pop_rev", 64'(core_rev_endian), 64'd1);
    n = 0;
    while (!core_rst_n && n < 100) begin
      tick();
      n++;
    end
    chk("reset_len", 64'(n), 64'd16);
    repeat (100) tick();
    core_done  = 1'b1;
    core_isize = 32'h400;
    core_crc   = 32'hDEADBEEF;
    tick();
    core_done = 1'b0;
    chk("capture_no_valid", 64'(sts_valid), 64'd0);
    tick();
    core_isize = 32'h1234;
    core_crc   = 32'h5678;
    chk("t1_valid", 64'(sts_valid), 64'd1);
    chk("t1_code", 64'(sts_code), 64'd0);
    chk("t1_tag", 64'(sts_tag), 64'd5);
    chk("t1_isize", 64'(sts_isize), 64'h400);
    chk("t1_crc", 64'(sts_crc), 64'hDEADBEEF);
    chk("t1_irq", 64'(irq), 64'd1);
    repeat (3) tick();
    chk("t1_isize_stable", 64'(sts_isize), 64'h400);
    chk("t1_irq_held", 64'(irq), 64'd1);
    chk("t1_btype_held", 64'(core_btype), 64'd1);
    sts_ready = 1'b1;
    tick();
    sts_ready = 1'b0;
    chk("t1_valid_drop", 64'(sts_valid), 64'd0);
    chk("t1_irq_drop", 64'(irq), 64'd0);

    // btype_err and done together -> code 1; irq_en=0 keeps irq low
    push(2'd2, 1'b0, 1'b0, 4'd3);
    wait_run();
    tick();
    core_btype_err = 1'b1;
    core_done      = 1'b1;
    tick();
    core_btype_err = 1'b0;
    core_done      = 1'b0;
    tick();
    chk("t2_valid", 64'(sts_valid), 64'd1);
    chk("t2_code", 64'(sts_code), 64'd1);
    chk("t2_tag", 64'(sts_tag), 64'd3);
    chk("t2_irq", 64'(irq), 64'd0);
    sts_ready = 1'b1;
    tick();
    sts_ready = 1'b0;

    // bsize_err beats done
    push(2'd0, 1'b0, 1'b0, 4'd9);
    wait_run();
    core_bsize_err = 1'b1;
    core_done      = 1'b1;
    tick();
    core_bsize_err = 1'b0;
    core_done      = 1'b0;
    tick();
    chk("t3_code", 64'(sts_code), 64'd2);
    sts_ready = 1'b1;
    tick();
    sts_ready = 1'b0;

    // Watchdog: 50 RUN cycles then CAPTURE
    timeout_cycles = 24'd50;
    push(2'd1, 1'b0, 1'b0, 4'd7);
    wait_run();
    n = 0;
    while (!sts_valid && n < 1000) begin
      tick();
      n++;
    end
    chk("to_run_plus_capture", 64'(n), 64'd51);
    chk("to_code", 64'(sts_code), 64'd3);
    chk("to_tag", 64'(sts_tag), 64'd7);
    sts_ready = 1'b1;
    tick();
    sts_ready = 1'b0;
    timeout_cycles = 24'd0;

    // Five back-to-back pushes while job A runs
    push(2'd1, 1'b0, 1'b0, 4'd1);
    wait_run();
    acc = 0;
    cmd_valid = 1'b1;
    cmd_tag   = 4'd2;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) acc++;
      tick();
      cmd_tag = 4'(2 + acc);
    end
    chk("q_accepted", 64'(acc), 64'd4);
    chk("q_ready_low", 64'(cmd_ready), 64'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("qa_tag", 64'(sts_tag), 64'd1);
    sts_ready = 1'b1;
    chk("q_full_no_pop", 64'(cmd_ready), 64'd0);
    tick();
    sts_ready = 1'b0;
    chk("q_full_with_pop", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    do_job(4'd2, 20);
    do_job(4'd3, 0);
    do_job(4'd4, 0);
    do_job(4'd5, 0);
    do_job(4'd6, 0);

    // Mid-job reset with 3 queued; also no watchdog with limit 0
    push(2'd3, 1'b1, 1'b1, 4'd10);
    push(2'd3, 1'b1, 1'b1, 4'd11);
    push(2'd3, 1'b1, 1'b1, 4'd12);
    push(2'd3, 1'b1, 1'b1, 4'd13);
    wait_run();
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (sts_valid) seen++;
      tick();
    end
    chk("no_timeout_0", 64'(seen), 64'd0);
    chk("mid_btype", 64'(core_btype), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mr_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("mr_btype", 64'(core_btype), 64'd0);
    chk("mr_rev", 64'(core_rev_endian), 64'd0);
    chk("mr_sts_valid", 64'(sts_valid), 64'd0);
    chk("mr_sts_tag", 64'(sts_tag), 64'd0);
    chk("mr_sts_isize", 64'(sts_isize), 64'd0);
    chk("mr_irq", 64'(irq), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (sts_valid || core_rst_n || irq) seen++;
      tick();
    end
    chk("mr_no_status", 64'(seen), 64'd0);
    chk("mr_ready_back", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
